control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Microcoded Moore FSM that drives every control input of the ARM data path.
- Consumes the data path's IR_Out, MFC and Flags.
- Sequences fetch, condition check, data-processing, word/byte load/store with immediate offset, and B/BL.
- Includes a memory-wait watchdog.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for MFC before error.
- ALU_ADD, 4'b0100: ALUA code for A+B.
- ALU_SUB, 4'b0010: ALUA code for A-B.
- ALU_PASS_A, 4'b1100: ALUA code that outputs A.
- ALU_PASS_B, 4'b1101: ALUA code that outputs B.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous, active-low reset.
- IR_Out  in  32  instruction register.
- MFC  in  1  memory function complete.
- Flags  in  4  {N,Z,C,V} from status register.
- MFA, RW_RAM, SALU, RF_RW, SSAB, SSOP, SMA, STA  out  1 each  data-path controls.
- MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN, ISE_EN, SGN_EN  out  1 each  data-path enables.
- DSS, WRA, SRA, SRB, SISE, SALUB  out  2 each  data-path selects.
- ALUA  out  4  ALU opcode when SALU=0.
- ERR  out  1  sticky memory-timeout error.
- STATE  out  4  current state code, for debug.

Behaviour:
- Encodings:
  - SRA: 0=Rn, 1=PC, 2=LR, 3=Rd.
  - SRB: 0=Rn, 1=PC, 2=Rd, 3=Rm.
  - WRA: 0=Rd, 1=PC, 2=LR, 3=Rn.
  - SALUB: 0=MDR, 1=const 4, 2=branch ext, 3=shifter.
  - SALU: 1 selects IR[24:21].
  - RF_RW=1 writes. RW_RAM=1 reads. SMA=1 selects memory data. DSS: 0=word, 1=byte.
  - Outputs not listed for a state are 0.
- Outputs are decoded combinationally from state and IR_Out (Moore plus IR). State register only.
- Reset (CLR=0, async): state=S_RST(0), all outputs 0, ERR=0, watchdog=0. Mid-operation reset aborts any memory access immediately (MFA drops in the same instant).
- S_RST: unconditionally -> S_F1.
- S_F1: SRA=1, ALUA=PASS_A, MAR_EN=1 (MAR<=PC). -> S_F2.
- S_F2: SRA=1, SALUB=1, ALUA=ADD, WRA=1, RF_RW=1 (PC<=PC+4). MFA=1, RW_RAM=1, DSS=0. -> S_F3.
- S_F3: MFA=1, RW_RAM=1, DSS=0.
  - While MFC=0: stay.
  - MFC=1: IR_EN=1, -> S_DEC.
- S_DEC: evaluate IR[31:28] against Flags using standard ARM conditions (EQ..AL; 1111 counts as false).
  - Fail: -> S_F1.
  - Else IR[27:26]=00 -> S_DP.
  - 01 with IR[25]=0 -> S_LS.
  - IR[27:25]=101: -> S_BL if IR[24]=1, else S_BR.
  - Anything else: NOP, -> S_F1.
- S_DP: SALU=1, SRA=0, SRB=3, SSOP=~IR[25], ISE_EN=IR[25], SHT_EN=1, SALUB=3, SR_EN=IR[20].
  - WRA=0, RF_RW=1 unless IR[24:23]=10 (TST/TEQ/CMP/CMN: no write).
  - -> S_F1.
- S_LS: SRA=0, SSOP=0, ISE_EN=1, SISE=0, SALUB=3, ALUA = IR[23] ? ADD : SUB, MAR_EN=1.
  - -> S_LD1 if IR[20]=1, else S_ST1.
- S_LD1: MFA=1, RW_RAM=1, DSS=IR[22], SMA=1, SGN_EN=1, MDR_EN=MFC.
  - Wait for MFC, then -> S_LD2.
- S_LD2: SALUB=0, ALUA=PASS_B, WRA=0, RF_RW=1. -> S_F1.
- S_ST1: SRA=3, ALUA=PASS_A, SMA=0, MDR_EN=1. -> S_ST2.
- S_ST2: MFA=1, RW_RAM=0, DSS=IR[22]. Wait for MFC, then -> S_F1.
- S_BL: SRA=1, ALUA=PASS_A, WRA=2, RF_RW=1 (LR<=PC). -> S_BR.
- S_BR: SRA=1, SALUB=2, ALUA=ADD, WRA=1, RF_RW=1. -> S_F1.
- Watchdog:
  - Counts cycles spent in any MFA state with MFC=0. Clears on leaving that state.
  - On reaching MEM_TIMEOUT: ERR<=1, -> S_HALT.
- S_HALT: all outputs 0. Exit only by reset.
- MFC asserted on the first cycle of a wait state completes in that cycle (minimum 1 cycle).

Test Plan:
- Reset: CLR=0 mid-S_F3 with MFA=1 -> MFA=0 and STATE=0 immediately. After release: S_F1 next edge, then MAR_EN=1, SRA=1.
- ADD R1,R2,R3 (IR=32'hE0821003), MFC after 2 cycles:
  - F1 -> F2 -> F3 (3 cycles) -> DEC -> DP.
  - In DP: SALU=1, RF_RW=1, WRA=0, SR_EN=0.
- CMP R1,#5 with Z-flag-dependent BEQ:
  - IR=32'hE3510005: DP has RF_RW=0, SR_EN=1, SSOP=0.
  - Next BEQ with Flags=4'b0100: S_BR taken. Flags=4'b0000: S_DEC -> S_F1.
- LDRB R0,[R1,#-4] (IR=32'hE5510004): S_LS ALUA=SUB; S_LD1 DSS=1, MDR_EN only when MFC=1; S_LD2 RF_RW=1, SALUB=0.
- BL (IR=32'hEB000010): S_BL with WRA=2, then S_BR with SALUB=2, WRA=1.
- STR with MFC held 0: ERR=1 after exactly 16 cycles in S_ST2, STATE=S_HALT, outputs 0 until CLR.

Source files
------------

// File: rtl/control_unit_if.sv
// Control bundle between the ARM control unit and its data path.
// Memory handshake: MFA is held high by the control unit for the whole access; the access
// completes on the rising edge where MFC is sampled high, and MFA may drop on the next cycle.
interface control_unit_if;
  logic [31:0] IR_Out;
  logic        MFC;
  logic [3:0]  Flags;
  logic        MFA, RW_RAM, SALU, RF_RW, SSAB, SSOP, SMA, STA;
  logic        MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN, ISE_EN, SGN_EN;
  logic [1:0]  DSS, WRA, SRA, SRB, SISE, SALUB;
  logic [3:0]  ALUA;

  modport master (
    input  IR_Out, MFC, Flags,
    output MFA, RW_RAM, SALU, RF_RW, SSAB, SSOP, SMA, STA,
    output MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN, ISE_EN, SGN_EN,
    output DSS, WRA, SRA, SRB, SISE, SALUB, ALUA
  );

  modport slave (
    output IR_Out, MFC, Flags,
    input  MFA, RW_RAM, SALU, RF_RW, SSAB, SSOP, SMA, STA,
    input  MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN, ISE_EN, SGN_EN,
    input  DSS, WRA, SRA, SRB, SISE, SALUB, ALUA
  );
endinterface

// File: rtl/control_unit.sv
// Moore control unit for the ARM data path: fetch, condition check, data processing,
// immediate-offset load/store and B/BL, with a watchdog on every memory wait.
module control_unit #(
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [3:0] ALU_ADD     = 4'b0100,
  parameter logic [3:0] ALU_SUB     = 4'b0010,
  parameter logic [3:0] ALU_PASS_A  = 4'b1100,
  parameter logic [3:0] ALU_PASS_B  = 4'b1101
) (
  input  logic               CLK,
  input  logic               CLR,
  control_unit_if.master     dp,
  output logic               ERR,
  output logic [3:0]         STATE
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,  S_F1  = 4'd1,  S_F2  = 4'd2,  S_F3   = 4'd3,
    S_DEC  = 4'd4,  S_DP  = 4'd5,  S_LS  = 4'd6,  S_LD1  = 4'd7,
    S_LD2  = 4'd8,  S_ST1 = 4'd9,  S_ST2 = 4'd10, S_BL   = 4'd11,
    S_BR   = 4'd12, S_HALT = 4'd13
  } state_e;

  localparam int WDW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(MEM_TIMEOUT - 1);

  state_e         state_q, state_d, done_st;
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           in_wait, cond_pass;
  logic           n_f, z_f, c_f, v_f;
  logic           unused_ir;

  assign {n_f, z_f, c_f, v_f} = dp.Flags;
  assign unused_ir = ^{dp.IR_Out[21], dp.IR_Out[19:0]};

  always_comb begin
    cond_pass = 1'b0;
    case (dp.IR_Out[31:28])
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = ~z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = ~c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = ~n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = ~v_f;
      4'h8: cond_pass = c_f & ~z_f;
      4'h9: cond_pass = ~c_f | z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = ~z_f & (n_f == v_f);
      4'hD: cond_pass = z_f | (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    err_d   = err_q;
    in_wait = 1'b0;
    done_st = S_F1;
    case (state_q)
      S_RST: state_d = S_F1;
      S_F1:  state_d = S_F2;
      S_F2:  state_d = S_F3;
      S_F3:  begin in_wait = 1'b1; done_st = S_DEC; end
      S_DEC: begin
        if (!cond_pass)                        state_d = S_F1;
        else if (dp.IR_Out[27:26] == 2'b00)    state_d = S_DP;
        else if (dp.IR_Out[27:25] == 3'b010)   state_d = S_LS;
        else if (dp.IR_Out[27:25] == 3'b101)   state_d = dp.IR_Out[24] ? S_BL : S_BR;
        else                                   state_d = S_F1;
      end
      S_DP:   state_d = S_F1;
      S_LS:   state_d = dp.IR_Out[20] ? S_LD1 : S_ST1;
      S_LD1:  begin in_wait = 1'b1; done_st = S_LD2; end
      S_LD2:  state_d = S_F1;
      S_ST1:  state_d = S_ST2;
      S_ST2:  begin in_wait = 1'b1; done_st = S_F1; end
      S_BL:   state_d = S_BR;
      S_BR:   state_d = S_F1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    // MFC wins over the watchdog, so completion on the last allowed cycle is still good.
    if (in_wait) begin
      if (dp.MFC) begin
        state_d = done_st;
      end else if (wd_q == WD_LAST) begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_RST;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign ERR   = err_q;
  assign STATE = state_q;

  always_comb begin
    dp.MFA = 1'b0;    dp.RW_RAM = 1'b0; dp.SALU = 1'b0;   dp.RF_RW = 1'b0;
    dp.SSAB = 1'b0;   dp.SSOP = 1'b0;   dp.SMA = 1'b0;    dp.STA = 1'b0;
    dp.MAR_EN = 1'b0; dp.SR_EN = 1'b0;  dp.MDR_EN = 1'b0; dp.IR_EN = 1'b0;
    dp.SHT_EN = 1'b0; dp.ISE_EN = 1'b0; dp.SGN_EN = 1'b0;
    dp.DSS = 2'd0;    dp.WRA = 2'd0;    dp.SRA = 2'd0;    dp.SRB = 2'd0;
    dp.SISE = 2'd0;   dp.SALUB = 2'd0;  dp.ALUA = 4'd0;
    case (state_q)
      S_F1: begin
        dp.SRA = 2'd1; dp.ALUA = ALU_PASS_A; dp.MAR_EN = 1'b1;
      end
      S_F2: begin
        dp.SRA = 2'd1; dp.SALUB = 2'd1; dp.ALUA = ALU_ADD; dp.WRA = 2'd1; dp.RF_RW = 1'b1;
        dp.MFA = 1'b1; dp.RW_RAM = 1'b1;
      end
      S_F3: begin
        dp.MFA = 1'b1; dp.RW_RAM = 1'b1; dp.IR_EN = dp.MFC;
      end
      S_DP: begin
        dp.SALU = 1'b1; dp.SRB = 2'd3; dp.SSOP = ~dp.IR_Out[25]; dp.ISE_EN = dp.IR_Out[25];
        dp.SHT_EN = 1'b1; dp.SALUB = 2'd3; dp.SR_EN = dp.IR_Out[20];
        dp.RF_RW = (dp.IR_Out[24:23] != 2'b10);
      end
      S_LS: begin
        dp.ISE_EN = 1'b1; dp.SALUB = 2'd3; dp.MAR_EN = 1'b1;
        dp.ALUA = dp.IR_Out[23] ? ALU_ADD : ALU_SUB;
      end
      S_LD1: begin
        dp.MFA = 1'b1; dp.RW_RAM = 1'b1; dp.DSS = {1'b0, dp.IR_Out[22]}; dp.SMA = 1'b1;
        dp.SGN_EN = 1'b1; dp.MDR_EN = dp.MFC;
      end
      S_LD2: begin
        dp.ALUA = ALU_PASS_B; dp.RF_RW = 1'b1;
      end
      S_ST1: begin
        dp.SRA = 2'd3; dp.ALUA = ALU_PASS_A; dp.MDR_EN = 1'b1;
      end
      S_ST2: begin
        dp.MFA = 1'b1; dp.DSS = {1'b0, dp.IR_Out[22]};
      end
      S_BL: begin
        dp.SRA = 2'd1; dp.ALUA = ALU_PASS_A; dp.WRA = 2'd2; dp.RF_RW = 1'b1;
      end
      S_BR: begin
        dp.SRA = 2'd1; dp.SALUB = 2'd2; dp.ALUA = ALU_ADD; dp.WRA = 2'd1; dp.RF_RW = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Cycle-level bench for control_unit: a per-instruction micro-step model pushes the expected
// control vector for every cycle; a negedge monitor pops and compares.
module tb_control_unit;

  localparam int         MEM_TIMEOUT = 16;
  localparam logic [3:0] ADD = 4'b0100, SUB = 4'b0010, PASS_A = 4'b1100, PASS_B = 4'b1101;
  localparam int         OW = 36;

  typedef struct packed {
    logic [3:0] state;
    logic       err;
    logic       mfa, rw_ram, salu, rf_rw, ssab, ssop, sma, sta;
    logic       mar_en, sr_en, mdr_en, ir_en, sht_en, ise_en, sgn_en;
    logic [1:0] dss, wra, sra, srb, sise, salub;
    logic [3:0] alua;
  } obs_t;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       err_o;
  logic [3:0] state_o;
  control_unit_if dp_if ();

  logic [OW-1:0] exp_q[$];
  int assert_cnt = 0;
  int fail_cnt   = 0;

  control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .dp    (dp_if),
    .ERR   (err_o),
    .STATE (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '0;
      a.state = state_o;  a.err = err_o;
      a.mfa = dp_if.MFA;  a.rw_ram = dp_if.RW_RAM; a.salu = dp_if.SALU; a.rf_rw = dp_if.RF_RW;
      a.ssab = dp_if.SSAB; a.ssop = dp_if.SSOP;  a.sma = dp_if.SMA;   a.sta = dp_if.STA;
      a.mar_en = dp_if.MAR_EN; a.sr_en = dp_if.SR_EN; a.mdr_en = dp_if.MDR_EN;
      a.ir_en = dp_if.IR_EN; a.sht_en = dp_if.SHT_EN; a.ise_en = dp_if.ISE_EN;
      a.sgn_en = dp_if.SGN_EN;
      a.dss = dp_if.DSS; a.wra = dp_if.WRA; a.sra = dp_if.SRA; a.srb = dp_if.SRB;
      a.sise = dp_if.SISE; a.salub = dp_if.SALUB; a.alua = dp_if.ALUA;
      assert_cnt++;
      if (a !== e) begin
        fail_cnt++;
        $display("FAIL ctl_vector t=%0t state act=%0d req=%0d vec act=%h req=%h",
                 $time, a.state, e.state, a, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    assert_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic obs_t st(input logic [3:0] s);
    obs_t o;
    o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return base ^ c[0];
  endfunction

  // ---------------- driver ----------------
  task automatic step(input obs_t o, input logic mfc);
    dp_if.MFC = mfc;
    exp_q.push_back(o);
    @(posedge CLK);
    #1;
  endtask

  task automatic mem_wait(input obs_t waiting, input obs_t done, input int lat, output bit halted);
    int n;
    n = (lat < MEM_TIMEOUT) ? lat : MEM_TIMEOUT;
    for (int k = 0; k < n; k++) step(waiting, 1'b0);
    halted = (lat >= MEM_TIMEOUT);
    if (!halted) step(done, 1'b1);
  endtask

  task automatic reset_dut();
    CLR = 1'b0;
    #1;
    check("reset_mfa_immediate", {31'd0, dp_if.MFA}, 32'd0);
    check("reset_state_immediate", {28'd0, state_o}, 32'd0);
    check("reset_err", {31'd0, err_o}, 32'd0);
    @(posedge CLK);
    #1;
    exp_q.push_back(st(4'd0));
    @(negedge CLK);
    #1;
    CLR = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic halt_tail();
    obs_t o;
    o = st(4'd13);
    o.err = 1'b1;
    repeat (3) step(o, 1'($urandom_range(0, 1)));
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic [3:0] fl, input int flat,
                           input int mlat, output bit halted);
    obs_t o, w, d;
    logic [3:0] opc;
    dp_if.IR_Out = ir;
    dp_if.Flags  = fl;
    halted = 1'b0;
    o = st(4'd1); o.sra = 2'd1; o.alua = PASS_A; o.mar_en = 1'b1;
    step(o, 1'($urandom_range(0, 1)));
    o = st(4'd2); o.sra = 2'd1; o.salub = 2'd1; o.alua = ADD; o.wra = 2'd1; o.rf_rw = 1'b1;
    o.mfa = 1'b1; o.rw_ram = 1'b1;
    step(o, 1'($urandom_range(0, 1)));
    w = st(4'd3); w.mfa = 1'b1; w.rw_ram = 1'b1;
    d = w; d.ir_en = 1'b1;
    mem_wait(w, d, flat, halted);
    if (halted) return;
    step(st(4'd4), 1'($urandom_range(0, 1)));
    if (!cond_ok(ir[31:28], fl)) return;
    if (ir[27:25] == 3'b000 || ir[27:25] == 3'b001) begin
      opc = ir[24:21];
      o = st(4'd5); o.salu = 1'b1; o.srb = 2'd3; o.ssop = !ir[25]; o.ise_en = ir[25];
      o.sht_en = 1'b1; o.salub = 2'd3; o.sr_en = ir[20];
      o.rf_rw = !(opc >= 4'd8 && opc <= 4'd11);
      step(o, 1'($urandom_range(0, 1)));
    end else if (ir[27:25] == 3'b010) begin
      o = st(4'd6); o.ise_en = 1'b1; o.salub = 2'd3; o.mar_en = 1'b1;
      o.alua = ir[23] ? ADD : SUB;
      step(o, 1'($urandom_range(0, 1)));
      if (ir[20]) begin
        w = st(4'd7); w.mfa = 1'b1; w.rw_ram = 1'b1; w.dss = {1'b0, ir[22]}; w.sma = 1'b1;
        w.sgn_en = 1'b1;
        d = w; d.mdr_en = 1'b1;
        mem_wait(w, d, mlat, halted);
        if (halted) return;
        o = st(4'd8); o.alua = PASS_B; o.rf_rw = 1'b1;
        step(o, 1'($urandom_range(0, 1)));
      end else begin
        o = st(4'd9); o.sra = 2'd3; o.alua = PASS_A; o.mdr_en = 1'b1;
        step(o, 1'($urandom_range(0, 1)));
        w = st(4'd10); w.mfa = 1'b1; w.dss = {1'b0, ir[22]};
        mem_wait(w, w, mlat, halted);
      end
    end else if (ir[27:25] == 3'b101) begin
      if (ir[24]) begin
        o = st(4'd11); o.sra = 2'd1; o.alua = PASS_A; o.wra = 2'd2; o.rf_rw = 1'b1;
        step(o, 1'($urandom_range(0, 1)));
      end
      o = st(4'd12); o.sra = 2'd1; o.salub = 2'd2; o.alua = ADD; o.wra = 2'd1; o.rf_rw = 1'b1;
      step(o, 1'($urandom_range(0, 1)));
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[27:26] = 2'b00;
      1: r[27:25] = 3'b010;
      2: r[27:25] = 3'b101;
      default: r[27:25] = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b110;
    endcase
    if ($urandom_range(0, 1) != 0) r[31:28] = 4'hE;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    obs_t o;
    bit   h;
    dp_if.IR_Out = 32'd0;
    dp_if.MFC    = 1'b0;
    dp_if.Flags  = 4'd0;
    reset_dut();

    // Abort a fetch that is waiting on memory.
    o = st(4'd1); o.sra = 2'd1; o.alua = PASS_A; o.mar_en = 1'b1;
    step(o, 1'b0);
    o = st(4'd2); o.sra = 2'd1; o.salub = 2'd1; o.alua = ADD; o.wra = 2'd1; o.rf_rw = 1'b1;
    o.mfa = 1'b1; o.rw_ram = 1'b1;
    step(o, 1'b0);
    o = st(4'd3); o.mfa = 1'b1; o.rw_ram = 1'b1;
    step(o, 1'b0);
    step(o, 1'b0);
    check("mid_fetch_mfa", {31'd0, dp_if.MFA}, 32'd1);
    reset_dut();

    run_instr(32'hE0821003, 4'b0000, 2, 0, h);   // ADD R1,R2,R3
    run_instr(32'hE3510005, 4'b0000, 0, 0, h);   // CMP R1,#5
    run_instr(32'h0A000010, 4'b0100, 1, 0, h);   // BEQ taken
    run_instr(32'h0A000010, 4'b0000, 1, 0, h);   // BEQ not taken
    run_instr(32'hE5510004, 4'b0000, 1, 3, h);   // LDRB R0,[R1,#-4]
    run_instr(32'hE5912004, 4'b0000, 0, 15, h);  // LDR, MFC on last allowed cycle
    run_instr(32'hE5912004, 4'b0000, 15, 0, h);  // fetch completing on last allowed cycle
    run_instr(32'hEB000010, 4'b0000, 0, 0, h);   // BL
    run_instr(32'hE5812000, 4'b0000, 0, 0, h);   // STR, MFC in first cycle
    run_instr(32'hF0821003, 4'b1111, 0, 0, h);   // NV never executes
    run_instr(32'hEC000000, 4'b0000, 0, 0, h);   // coprocessor space: NOP

    for (int i = 0; i < 60; i++) begin
      run_instr(rand_ir(), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                $urandom_range(0, 5), h);
    end

    run_instr(32'hE5C12000, 4'b0000, 0, 20, h);  // STRB never acknowledged
    check("store_timeout_halted", {31'd0, h}, 32'd1);
    halt_tail();
    reset_dut();
    run_instr(32'hE5D12000, 4'b0000, 0, 30, h);  // LDRB never acknowledged
    halt_tail();
    reset_dut();
    run_instr(32'hE0821003, 4'b0000, 0, 0, h);

    @(negedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
